// File: rtl/mem_stream_reader.sv
// Purpose : read-side master for a 1-cycle-latency single-port RAM; streams xfer_len
//           words from base_addr upward on a valid/ready interface.
// Latency : start edge -> RAM read issued next cycle -> s_valid two edges after start;
//           one word per cycle sustained while s_ready is held high.
// Backpres: a 2-entry skid FIFO plus a credit check on reads; s_ready low stalls
//           reads once FIFO + in-flight read would reach 2. s_data is held until taken.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start               1-cycle request, only honoured in IDLE
//   i_base_addr           first word address, captured with i_start
//   i_xfer_len            word count, captured with i_start (0 is legal, >depth wraps)
//   o_busy                high while a transfer owns the RAM read port
//   o_done                1-cycle pulse after the last word is handed off
//   o_mem_rd_en           RAM read enable
//   o_mem_addr            RAM read address (read pointer register)
//   i_mem_d_out           RAM read data, valid the cycle after a read edge
//   o_s_valid             stream valid
//   i_s_ready             stream ready
//   o_s_data              stream data (FIFO head register)

module mem_stream_reader #(
    parameter int width   = 8,
    parameter int depth   = 256,
    parameter int addr_sz = 8,
    parameter int len_sz  = 9
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [addr_sz-1:0] i_base_addr,
    input  logic [len_sz-1:0]  i_xfer_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_mem_rd_en,
    output logic [addr_sz-1:0] o_mem_addr,
    input  logic [width-1:0]   i_mem_d_out,
    output logic               o_s_valid,
    input  logic               i_s_ready,
    output logic [width-1:0]   o_s_data
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [addr_sz-1:0] ADDR_LAST = addr_sz'(depth - 1);
    localparam logic [addr_sz-1:0] ADDR_ONE  = addr_sz'(1);
    localparam logic [len_sz-1:0]  LEN_ONE   = len_sz'(1);
    localparam logic [1:0]         CNT_ONE   = 2'd1;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [addr_sz-1:0] r_rd_ptr;
    logic [len_sz-1:0]  r_issue_cnt;
    logic [len_sz-1:0]  r_accept_cnt;
    logic               r_inflight;
    logic               r_done;

    // ------------------------------------------------------------------
    // Output FIFO (2 entries) registers
    // ------------------------------------------------------------------
    logic [width-1:0]   r_fifo_mem [2];
    logic               r_fifo_wr_idx;
    logic               r_fifo_rd_idx;
    logic [1:0]         r_fifo_cnt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_fill;
    logic               w_rd_en;
    logic               w_start_run;
    logic               w_start_zero;
    logic               w_last_pop;
    logic [addr_sz-1:0] w_rd_ptr_nxt;

    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_push       = r_inflight;
    assign w_pop        = ~w_fifo_empty & i_s_ready;

    // Occupancy the FIFO would have after this edge if no new read were issued:
    // stored words, plus the read already in flight, minus a word leaving now.
    // A new read is only allowed when that leaves room for its data.
    assign w_fill  = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == S_RUN) & (r_issue_cnt != '0) & (w_fill < 3'd2);

    assign w_start_run  = (r_state == S_IDLE) & i_start & (i_xfer_len != '0);
    assign w_start_zero = (r_state == S_IDLE) & i_start & (i_xfer_len == '0);

    // The last word can only leave in DRAIN: issue_cnt reaches 0 on the edge of
    // the final read, at least two edges before that word can be handed off.
    assign w_last_pop = (r_state == S_DRAIN) & w_pop & (r_accept_cnt == LEN_ONE);

    // Explicit wrap keeps non-power-of-two depths in range.
    assign w_rd_ptr_nxt = (r_rd_ptr == ADDR_LAST) ? '0 : (r_rd_ptr + ADDR_ONE);

    // ------------------------------------------------------------------
    // Transfer FSM, read pointer and counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            r_issue_cnt  <= '0;
            r_accept_cnt <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= w_start_zero | w_last_pop;

            case (r_state)
                S_IDLE: begin
                    if (w_start_run) begin
                        r_state      <= S_RUN;
                        r_rd_ptr     <= i_base_addr;
                        r_issue_cnt  <= i_xfer_len;
                        r_accept_cnt <= i_xfer_len;
                    end
                end

                S_RUN: begin
                    if (w_rd_en) begin
                        r_rd_ptr    <= w_rd_ptr_nxt;
                        r_issue_cnt <= r_issue_cnt - LEN_ONE;
                        if (r_issue_cnt == LEN_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    if (w_pop) begin
                        r_accept_cnt <= r_accept_cnt - LEN_ONE;
                    end
                end

                S_DRAIN: begin
                    if (w_pop) begin
                        r_accept_cnt <= r_accept_cnt - LEN_ONE;
                    end
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: data captured from the RAM the edge after a read.
    // The credit rule on w_rd_en means a push never meets a full FIFO
    // unless a pop happens on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_fifo_wr_idx <= 1'b0;
            r_fifo_rd_idx <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_fifo_wr_idx] <= i_mem_d_out;
                r_fifo_wr_idx             <= ~r_fifo_wr_idx;
            end
            if (w_pop) begin
                r_fifo_rd_idx <= ~r_fifo_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_mem_rd_en = w_rd_en;
    assign o_mem_addr  = r_rd_ptr;
    assign o_s_valid   = ~w_fifo_empty;
    // Head entry only changes on a pop, so data is stable while stalled.
    assign o_s_data    = r_fifo_mem[r_fifo_rd_idx];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: behavioural 1-cycle RAM with RAM[i]=i, a table of
// transfers driven in a loop, a scoreboard queue of expected words checked on every
// handshake, and a hand-written reset-during-drain sequence.

module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] xfer_len;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_d_out;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] ram [256];
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_stream_reader #(
        .width   (8),
        .depth   (256),
        .addr_sz (8),
        .len_sz  (9)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_xfer_len  (xfer_len),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_rd_en (mem_rd_en),
        .o_mem_addr  (mem_addr),
        .i_mem_d_out (mem_d_out),
        .o_s_valid   (s_valid),
        .i_s_ready   (s_ready),
        .o_s_data    (s_data)
    );

    // Behavioural RAM: registered address, data valid the cycle after the read edge.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = i[7:0];
        mem_d_out = 8'h00;
    end
    always @(posedge clk) if (mem_rd_en) mem_d_out <= ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: scoreboard, hold stability and FIFO/credit model
    // ------------------------------------------------------------------
    int         occ_m;
    int         infl_m;
    int         pop_i;
    logic       prev_v;
    logic       prev_r;
    logic [7:0] prev_d;
    logic [7:0] exp_d;

    always @(negedge clk) begin
        #1;
        if (rst || !mon_en) begin
            occ_m  = 0;
            infl_m = 0;
            prev_v = 1'b0;
            prev_r = 1'b0;
            prev_d = 8'h00;
        end else begin
            pop_i = (s_valid && s_ready) ? 1 : 0;
            check("valid_vs_model", s_valid, occ_m != 0);
            if (prev_v && !prev_r) begin
                check("hold_valid", s_valid, 1);
                check("hold_data", s_data, prev_d);
            end
            if (occ_m + infl_m - pop_i >= 2) check("credit_block", mem_rd_en, 0);
            if (pop_i == 1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", s_data, $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("data", s_data, exp_d);
                end
            end
            occ_m  = occ_m + infl_m - pop_i;
            infl_m = mem_rd_en ? 1 : 0;
            prev_v = s_valid;
            prev_r = s_ready;
            prev_d = s_data;
        end
    end

    // ------------------------------------------------------------------
    // Transfer table
    // mode: 0 = ready held high, 1 = ready toggling with a 5-cycle stall, 2 = random
    // exp_done: negedge index (after the start edge) where done is seen, -1 = not fixed
    // restart_n: cycle at which a second start is pulsed while busy, -1 = none
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         mode;
        int         exp_done;
        int         restart_n;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx, input vec_t v);
        int         done_n;
        int         first_v;
        int         rd_n;
        int         done_cnt;
        int         n;
        int         limit;
        logic [7:0] a;
        done_n   = -1;
        first_v  = -1;
        rd_n     = 0;
        done_cnt = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        xfer_len  = v.len;
        s_ready   = 1'b1;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.base + 8'(i);
            exp_q.push_back(ram[a]);
        end
        limit = int'(v.len) * 4 + 40;
        n = 0;
        while (n < limit && (done_n < 0 || n < done_n + 4)) begin
            @(negedge clk);
            n++;
            start = (n == v.restart_n);
            if (start) begin
                base_addr = 8'h90;
                xfer_len  = 9'd5;
            end
            case (v.mode)
                0:       s_ready = 1'b1;
                1:       s_ready = (n >= 9 && n <= 13) ? 1'b0 : (n % 2 == 1);
                default: s_ready = 1'($urandom_range(0, 1));
            endcase
            #2;
            if (mem_rd_en) rd_n++;
            if (n == 1) begin
                check($sformatf("v%0d_rd_en_first", idx), mem_rd_en, v.len != 0);
                check($sformatf("v%0d_busy_first", idx), busy, v.len != 0);
            end
            if (s_valid && first_v < 0) first_v = n;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
        end
        check($sformatf("v%0d_done_seen", idx), done_n >= 0, 1);
        check($sformatf("v%0d_done_count", idx), done_cnt, 1);
        check($sformatf("v%0d_read_count", idx), rd_n, v.len);
        check($sformatf("v%0d_words_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_busy_end", idx), busy, 0);
        check($sformatf("v%0d_valid_end", idx), s_valid, 0);
        if (v.exp_done >= 0) check($sformatf("v%0d_done_cycle", idx), done_n, v.exp_done);
        if (v.len != 0) check($sformatf("v%0d_first_valid", idx), first_v, 3);
        else            check($sformatf("v%0d_never_valid", idx), first_v, -1);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{8'h10, 9'd4,   0, 7,   -1};
        vecs[1] = '{8'hFE, 9'd4,   0, 7,   -1};
        vecs[2] = '{8'h20, 9'd8,   1, -1,  -1};
        vecs[3] = '{8'h05, 9'd0,   0, 1,   -1};
        vecs[4] = '{8'hF0, 9'd300, 0, 303, -1};
        vecs[5] = '{8'h00, 9'd1,   2, -1,  -1};
        vecs[6] = '{8'h80, 9'd12,  2, -1,  -1};
        vecs[7] = '{8'h40, 9'd6,   0, 9,   3};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        xfer_len  = 9'd0;
        s_ready   = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", s_valid, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", s_data, 0);
        repeat (2) @(negedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Reset during DRAIN with both FIFO entries occupied.
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h30;
        xfer_len  = 9'd2;
        s_ready   = 1'b0;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("drain_busy", busy, 1);
        check("drain_valid", s_valid, 1);
        check("drain_head", s_data, 8'h30);
        check("drain_no_read", mem_rd_en, 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_valid", s_valid, 0);
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_data", s_data, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        run_vec(8, '{8'h30, 9'd3, 0, 6, -1});

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
